// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD write controller.
// After reset it waits T_PWRUP cycles and then sends the four-command
// init sequence. After that it accepts one byte at a time from a
// valid/ready request port and paces each write as a setup, enable
// and hold phase.
// All outputs are registered. Each one is computed from the next-state
// values, so a new state and its outputs appear on the same edge.
module lcd_ctrl #(
  parameter int T_PWRUP = 100,
  parameter int T_SU    = 2,
  parameter int T_EN    = 4,
  parameter int T_WAIT  = 50,
  parameter int T_LONG  = 200
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic        req_ready_o,
  output logic        init_done_o,
  output logic [31:0] lcd_o
);

  localparam int CW = 16;

  localparam logic [CW-1:0] PWRUP_C = CW'(T_PWRUP);
  localparam logic [CW-1:0] SU_C    = CW'(T_SU);
  localparam logic [CW-1:0] EN_C    = CW'(T_EN);
  localparam logic [CW-1:0] WAIT_C  = CW'(T_WAIT);
  localparam logic [CW-1:0] LONG_C  = CW'(T_LONG);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [2:0] {
    PWRUP  = 3'd0,
    IDLE   = 3'd1,
    SETUP  = 3'd2,
    ENABLE = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            done_q, done_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic [31:0]     lcd_q, lcd_d;
  logic            last;

  // Power-up init commands: function set (8-bit, 2 lines), display on,
  // clear, entry mode increment.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) are slow on the panel and
  // need the long hold. Character data never does.
  function automatic logic [CW-1:0] hold_len(input logic rs, input logic [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) hold_len = LONG_C;
    else                                                  hold_len = WAIT_C;
  endfunction

  assign last        = (cnt_q <= ONE_C);
  assign req_ready_o = ready_q;
  assign init_done_o = done_q;
  assign lcd_o       = lcd_q;

  // Next-state, next-counter and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = done_q;
    rs_d    = rs_q;
    data_d  = data_q;

    case (state_q)
      PWRUP: begin
        if (last) begin
          state_d = SETUP;
          cnt_d   = SU_C;
          idx_d   = 2'd0;
          rs_d    = 1'b0;
          data_d  = init_cmd(2'd0);
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end

      IDLE: begin
        // ready_q is already gated by init completion.
        if (req_valid_i && ready_q) begin
          state_d = SETUP;
          cnt_d   = SU_C;
          rs_d    = req_rs_i;
          data_d  = req_data_i;
        end
      end

      SETUP: begin
        if (last) begin
          state_d = ENABLE;
          cnt_d   = EN_C;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end

      ENABLE: begin
        if (last) begin
          state_d = HOLD;
          cnt_d   = hold_len(rs_q, data_q);
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end

      HOLD: begin
        if (!last) begin
          cnt_d = cnt_q - ONE_C;
        end else if (done_q) begin
          state_d = IDLE;
        end else if (idx_q == 2'd3) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = SETUP;
          cnt_d   = SU_C;
          idx_d   = idx_q + 2'd1;
          rs_d    = 1'b0;
          data_d  = init_cmd(idx_q + 2'd1);
        end
      end

      default: begin
        state_d = PWRUP;
        cnt_d   = PWRUP_C;
      end
    endcase

    ready_d = (state_d == IDLE) && done_d;
    // Panel word: ON, twenty zero bits, EN, RS, RW (always write), DATA.
    lcd_d   = {1'b1, 20'b0, (state_d == ENABLE), rs_d, 1'b0, data_d};
  end

  // State, counter and registered outputs. Reset clears everything
  // immediately and restarts the power-up wait.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PWRUP;
      cnt_q   <= PWRUP_C;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      lcd_q   <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments here, so every register samples
      // the values from before this edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      lcd_q   <= lcd_d;
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with default timing parameters.
// Cycle k is the k-th rising edge after reset release. Outputs are
// sampled on the falling edge that follows each rising edge.
module tb_lcd_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_rs;
  logic [7:0]  req_data;
  logic        req_ready;
  logic        init_done;
  logic [31:0] lcd;

  int vectors = 0;
  int errors  = 0;

  lcd_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_rs_i    (req_rs),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .init_done_o (init_done),
    .lcd_o       (lcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and stop on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one request. Then measure the cycles until ready returns, how
  // many cycles EN was high, and the last cycle on which EN was high
  // (the accepting edge is cycle 0).
  task automatic xfer(input logic rs, input logic [7:0] d,
                      output int lat, output int ens, output int last_en);
    int j;
    req_rs    = rs;
    req_data  = d;
    req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    j = 0; ens = 0; last_en = -1;
    while (!req_ready && j < 1000) begin
      if (lcd[10]) begin ens++; last_en = j; end
      tick(1);
      j++;
    end
    lat = req_ready ? j : -1;
  endtask

  int          en_cnt, ready_rise, done_rise, rw_viol, rs_any;
  int          en_cyc [4];
  logic [7:0]  en_data [4];
  logic        prev_en, on_c1;
  logic [31:0] exp_lcd;
  int          lat, ens, last_en, j;

  initial begin
    rst_n = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    // Reset is asserted and no clock edge has occurred yet.
    check("rst_lcd_noclk", lcd, 32'h0);
    check("rst_ready_noclk", {31'b0, req_ready}, 32'h0);
    check("rst_done_noclk", {31'b0, init_done}, 32'h0);
    tick(2);
    check("rst_lcd_clk", lcd, 32'h0);

    // This request is presented during power-up and init; it must be ignored.
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;

    rst_n = 1'b1;
    en_cnt = 0; ready_rise = -1; done_rise = -1; rw_viol = 0; rs_any = 0;
    prev_en = 1'b0; on_c1 = 1'b0;
    for (int k = 0; k < 4; k++) begin en_cyc[k] = 0; en_data[k] = 8'h00; end
    for (int c = 1; c <= 474; c++) begin
      tick(1);
      if (c == 1) on_c1 = lcd[31];
      if (lcd[10] && !prev_en) begin
        if (en_cnt < 4) begin en_cyc[en_cnt] = c; en_data[en_cnt] = lcd[7:0]; end
        if (lcd[9]) rs_any++;
        en_cnt++;
      end
      prev_en = lcd[10];
      if (req_ready && ready_rise < 0) ready_rise = c;
      if (init_done && done_rise < 0) done_rise = c;
      if (lcd[8]) rw_viol++;
    end
    check("on_after_first_edge", {31'b0, on_c1}, 32'h1);
    check("first_en_cycle", en_cyc[0], 102);
    check("init_byte0", {24'b0, en_data[0]}, 32'h38);
    check("init_byte1", {24'b0, en_data[1]}, 32'h0C);
    check("init_byte2", {24'b0, en_data[2]}, 32'h01);
    check("init_byte3", {24'b0, en_data[3]}, 32'h06);
    check("clear_gap", en_cyc[3] - en_cyc[2], 206);
    check("init_en_pulses", en_cnt, 4);
    check("init_rs_zero", rs_any, 0);
    check("ready_rise_cycle", ready_rise, 474);
    check("done_rise_cycle", done_rise, 474);
    check("rw_always_zero", rw_viol, 0);

    // Character 'A'. req_valid stays high and the data changes
    // mid-transfer, so no extra pulse may appear.
    req_rs = 1'b1; req_data = 8'h41;
    tick(1);
    req_rs = 1'b0; req_data = 8'h99;
    for (int k = 0; k < 56; k++) begin
      if (k >= 2 && k <= 5) exp_lcd = 32'h8000_0641;
      else                  exp_lcd = 32'h8000_0241;
      check($sformatf("char_lcd_c%0d", k), lcd, exp_lcd);
      check($sformatf("char_ready_c%0d", k), {31'b0, req_ready}, 32'h0);
      tick(1);
    end
    check("char_ready_back", {31'b0, req_ready}, 32'h1);
    check("char_idle_lcd", lcd, 32'h8000_0241);
    // The still-held request is taken now, and only now.
    tick(1);
    check("held_req_accept", lcd, 32'h8000_0099);
    check("held_req_ready_low", {31'b0, req_ready}, 32'h0);
    req_valid = 1'b0;
    j = 0;
    while (!req_ready && j < 300) begin tick(1); j++; end
    check("held_req_latency", j, 56);

    // Clear display: long hold.
    xfer(1'b0, 8'h01, lat, ens, last_en);
    check("clear_latency", lat, 206);
    check("clear_en_cycles", ens, 4);
    check("clear_last_en", last_en, 5);
    xfer(1'b0, 8'h02, lat, ens, last_en);
    check("home02_latency", lat, 206);
    xfer(1'b0, 8'h03, lat, ens, last_en);
    check("home03_latency", lat, 206);
    xfer(1'b1, 8'h03, lat, ens, last_en);
    check("char03_latency", lat, 56);
    xfer(1'b0, 8'h04, lat, ens, last_en);
    check("cmd04_latency", lat, 56);
    xfer(1'b0, 8'h00, lat, ens, last_en);
    check("cmd00_latency", lat, 56);

    // Reset during ENABLE.
    req_rs = 1'b1; req_data = 8'h41; req_valid = 1'b1;
    tick(1);
    req_valid = 1'b0;
    tick(2);
    check("pre_reset_enable", lcd, 32'h8000_0641);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_lcd_async", lcd, 32'h0);
    check("midrst_ready", {31'b0, req_ready}, 32'h0);
    check("midrst_done", {31'b0, init_done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("rerun_c1", lcd, 32'h8000_0000);
    check("rerun_done_low", {31'b0, init_done}, 32'h0);
    tick(99);
    check("rerun_setup_c100", lcd, 32'h8000_0038);
    tick(2);
    check("rerun_en_c102", lcd, 32'h8000_0438);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter T_PWRUP, default 100: cycles to wait after reset before the first init command.
REQ-002 SHALL have parameter T_SU, default 2: cycles RS/DATA are driven with EN low before each EN pulse.
REQ-003 SHALL have parameter T_EN, default 4: cycles EN is held high per transfer.
REQ-004 SHALL have parameter T_WAIT, default 50: cycles EN is held low after a normal transfer.
REQ-005 SHALL have parameter T_LONG, default 200: cycles EN is held low after command 0x01 or 0x02/0x03.
REQ-006 SHALL have clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have rst_ni, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have req_valid_i, input, 1: a transfer request is present.
REQ-009 SHALL have req_rs_i, input, 1: register select, 0 = command, 1 = character data.
REQ-010 SHALL have req_data_i, input, 8: command or character byte.
REQ-011 SHALL have req_ready_o, output, 1: the controller accepts a request this cycle.
REQ-012 SHALL have init_done_o, output, 1: the power-up init sequence has completed.
REQ-013 SHALL have lcd_o, output, 32: panel word; [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA, all other bits 0.

Function
REQ-014 SHALL implement FSM states PWRUP, IDLE, SETUP, ENABLE, HOLD with one down-counter of at least 16 bits.
REQ-015 SHALL leave reset in PWRUP, count T_PWRUP cycles, then issue init commands 0x38, 0x0C, 0x01, 0x06 in that order with RS=0.
REQ-016 SHALL run each transfer as SETUP (T_SU cycles, EN=0) -> ENABLE (T_EN cycles, EN=1) -> HOLD (T_LONG cycles if RS=0 and DATA is 0x01, 0x02 or 0x03, else T_WAIT cycles, EN=0).
REQ-017 SHALL, on leaving HOLD, go to the next init command if the init sequence is unfinished, else to IDLE.
REQ-018 SHALL set init_done_o to 1 on leaving HOLD of command 0x06, and hold it at 1 until reset.
REQ-019 SHALL drive req_ready_o to 1 only in IDLE with init_done_o = 1, as a registered output.
REQ-020 SHALL accept a request on a rising edge with req_valid_i & req_ready_o, capture RS and DATA, and enter SETUP on that edge.
REQ-021 SHALL ignore req_valid_i, req_rs_i and req_data_i while req_ready_o = 0, and SHALL NOT queue requests.
REQ-022 SHALL hold lcd_o[9] and lcd_o[7:0] stable through SETUP, ENABLE and HOLD of one transfer.
REQ-023 SHALL keep RW (lcd_o[8]) at 0 at all times; the panel busy flag is never read.
REQ-024 SHALL drive lcd_o as a registered output, with ON = 1 in every state after the first clock edge following reset release.
REQ-025 SHALL reassert req_ready_o exactly T_SU+T_EN+T_WAIT (or T_SU+T_EN+T_LONG) cycles after the accepting edge.
REQ-026 SHALL treat every timing parameter as at least 1; a parameter of 0 is not supported.

Reset
REQ-027 SHALL, while rst_ni = 0, force lcd_o = 32'h0, req_ready_o = 0, init_done_o = 0, state = PWRUP and counter = T_PWRUP, independent of clk_i.
REQ-028 SHALL, on reset asserted mid-transfer (any state), abort that transfer and restart the full init sequence after release.

Verification
REQ-029 SHALL pass this scenario with default parameters: reset release -> first EN rise carries DATA=0x38 RS=0 at cycle 102; init_done_o and req_ready_o rise at cycle 474; EN pulses total 4.
REQ-030 SHALL pass this scenario: after init, accept {rs=1, data=0x41} -> lcd_o = 32'h8000_0241 for 2 cycles, then 32'h8000_0641 for 4 cycles, then 32'h8000_0241 for 50 cycles, then req_ready_o = 1.
REQ-031 SHALL pass this scenario: accept command 0x01 -> EN low for 200 cycles after the pulse; req_ready_o returns after 206 cycles.
REQ-032 SHALL pass this scenario: req_valid_i held high with changing data during a transfer -> no extra EN pulse; the next byte is accepted only when req_ready_o = 1.
REQ-033 SHALL pass this scenario: rst_ni pulsed low during ENABLE -> lcd_o = 0 immediately, without a clock edge; after release the init sequence repeats, first byte 0x38.
REQ-034 SHALL pass this scenario: req_valid_i high during PWRUP/init -> ignored; req_ready_o stays 0 until cycle 474.
